uart_block_framer: RTL

- Byte/block framing layer between the UART byte engines and the RSA/AES hybrid decrypt core.
- Receive side: assembles MSB-first UART bytes into BLOCK_BYTES-wide blocks and tags the first block of each session as the key block.
- Transmit side: serialises result blocks back to the UART TX byte interface, MSB first.
- Adds what the fixed 32-in/16-out top lacked: configurable block width, session length, inter-byte timeout and overrun detection.

---
 rtl/uart_framer_pkg.sv | 19 +
 rtl/uart_block_framer_serializer.sv | 88 ++++++++
 rtl/uart_block_framer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_framer_pkg.sv
// Shared types and constants for the UART block framer.
package uart_framer_pkg;

    // Receive-side session tracking: the first block after (re)arming is the key block.
    typedef enum logic {
        EXPECT_KEY  = 1'b0,
        EXPECT_DATA = 1'b1
    } session_e;

    // Transmit serialiser states.
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    // Ten byte times at 115200 baud with a 100 MHz clock.
    localparam int UART_DEFAULT_TIMEOUT = 86800;

endpackage

// File: rtl/uart_block_framer_serializer.sv
// TX path: loads a result block in parallel and hands it to the UART TX
// byte interface one byte at a time, most significant byte first.
module block_serializer
    import uart_framer_pkg::*;
#(
    parameter int BLOCK_BYTES = 16
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*BLOCK_BYTES-1:0] blk_data,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int W  = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BYTES - 1);

    tx_state_e       state_reg, state_next;
    logic [W-1:0]    shreg_reg, shreg_next;
    logic [W-1:0]    shreg_shifted;
    logic [CW-1:0]   cnt_reg, cnt_next;

    // Shift the block up by one byte lane; zeros fill in from the bottom so the
    // register is empty once the last byte has gone out.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign shreg_shifted[7:0] = 8'h00;
            end else begin : g_upper
                assign shreg_shifted[8*gi +: 8] = shreg_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    // State, shift register and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TX_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Load on the block handshake, advance one byte per TX handshake.
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            TX_IDLE: begin
                if (blk_valid) begin
                    shreg_next = blk_data;
                    cnt_next   = '0;
                    state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_ready) begin
                    shreg_next = shreg_shifted;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = TX_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    assign blk_ready = (state_reg == TX_IDLE);
    assign tx_valid  = (state_reg == TX_SEND);
    assign tx_byte   = shreg_reg[W-1 -: 8];

endmodule

// File: rtl/uart_block_framer.sv
// Byte/block framing between the UART byte engines and the decrypt core.
// RX: packs MSB-first bytes into blocks, tags the first block of each session
// as the key block, detects inter-byte timeout and overrun.
// TX: forwards result blocks to block_serializer.
module uart_block_framer
    import uart_framer_pkg::*;
#(
    parameter int BLOCK_BYTES    = 16,
    parameter int DATA_BLOCKS    = 1,
    parameter int TIMEOUT_CYCLES = UART_DEFAULT_TIMEOUT
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_is_key,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    input  logic [8*BLOCK_BYTES-1:0] tx_blk_data,
    input  logic                     tx_blk_valid,
    output logic                     tx_blk_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     err_timeout,
    output logic                     err_overrun
);

    localparam int W   = 8 * BLOCK_BYTES;
    localparam int BCW = $clog2(BLOCK_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DCW = (DATA_BLOCKS > 0) ? $clog2(DATA_BLOCKS + 1) : 1;

    localparam logic [BCW-1:0] BC_LAST = BCW'(BLOCK_BYTES - 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(BLOCK_BYTES);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DATA_BLOCKS - 1);

    // Assembly state
    logic [W-1:0]    shreg_reg, shreg_next;
    logic [W-1:0]    shreg_shifted;
    logic [BCW-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [TW-1:0]   idle_cnt_reg, idle_cnt_next;

    // Session state
    session_e        session_reg, session_next;
    logic [DCW-1:0]  data_cnt_reg, data_cnt_next;

    // Holding register
    logic [W-1:0]    hold_data_reg, hold_data_next;
    logic            hold_key_reg, hold_key_next;
    logic            hold_valid_reg, hold_valid_next;

    // Error pulses
    logic            err_timeout_reg, err_timeout_next;
    logic            err_overrun_reg, err_overrun_next;

    // Transfer into the holding register this cycle
    logic            xfer;
    logic [W-1:0]    xfer_data;
    logic            handoff;
    logic            hold_free;

    // Incoming byte enters the bottom lane; earlier bytes move towards the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign shreg_shifted[7:0] = rx_byte;
            end else begin : g_upper
                assign shreg_shifted[8*gi +: 8] = shreg_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign handoff   = hold_valid_reg & blk_ready;
    assign hold_free = ~hold_valid_reg | handoff;

    // All receive-side state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg       <= '0;
            byte_cnt_reg    <= '0;
            idle_cnt_reg    <= '0;
            session_reg     <= EXPECT_KEY;
            data_cnt_reg    <= '0;
            hold_data_reg   <= '0;
            hold_key_reg    <= 1'b0;
            hold_valid_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            shreg_reg       <= shreg_next;
            byte_cnt_reg    <= byte_cnt_next;
            idle_cnt_reg    <= idle_cnt_next;
            session_reg     <= session_next;
            data_cnt_reg    <= data_cnt_next;
            hold_data_reg   <= hold_data_next;
            hold_key_reg    <= hold_key_next;
            hold_valid_reg  <= hold_valid_next;
            err_timeout_reg <= err_timeout_next;
            err_overrun_reg <= err_overrun_next;
        end
    end

    // Assembly, timeout, overrun, holding-register and session next state.
    always_comb begin
        shreg_next       = shreg_reg;
        byte_cnt_next    = byte_cnt_reg;
        idle_cnt_next    = idle_cnt_reg;
        session_next     = session_reg;
        data_cnt_next    = data_cnt_reg;
        hold_data_next   = hold_data_reg;
        hold_key_next    = hold_key_reg;
        hold_valid_next  = hold_valid_reg;
        err_timeout_next = 1'b0;
        err_overrun_next = 1'b0;
        xfer             = 1'b0;
        xfer_data        = shreg_reg;

        if (byte_cnt_reg == BC_FULL) begin
            // Complete block waiting for the holding register; new bytes are lost.
            idle_cnt_next = '0;
            if (rx_valid) begin
                err_overrun_next = 1'b1;
            end
            if (hold_free) begin
                xfer          = 1'b1;
                xfer_data     = shreg_reg;
                shreg_next    = '0;
                byte_cnt_next = '0;
            end
        end else if (rx_valid) begin
            // A byte arriving always beats a timeout in the same cycle.
            idle_cnt_next = '0;
            if (byte_cnt_reg == BC_LAST) begin
                if (hold_free) begin
                    xfer          = 1'b1;
                    xfer_data     = shreg_shifted;
                    shreg_next    = '0;
                    byte_cnt_next = '0;
                end else begin
                    shreg_next    = shreg_shifted;
                    byte_cnt_next = BC_FULL;
                end
            end else begin
                shreg_next    = shreg_shifted;
                byte_cnt_next = byte_cnt_reg + BCW'(1);
            end
        end else if (byte_cnt_reg != '0) begin
            // Partial block: abandon it if the line stays quiet too long.
            if (idle_cnt_reg == TO_LAST) begin
                err_timeout_next = 1'b1;
                shreg_next       = '0;
                byte_cnt_next    = '0;
                idle_cnt_next    = '0;
            end else begin
                idle_cnt_next = idle_cnt_reg + TW'(1);
            end
        end else begin
            idle_cnt_next = '0;
        end

        // Consumer takes the held block; a simultaneous transfer overrides below.
        if (handoff) begin
            hold_valid_next = 1'b0;
            hold_data_next  = '0;
            hold_key_next   = 1'b0;
        end

        if (xfer) begin
            hold_valid_next = 1'b1;
            hold_data_next  = xfer_data;
            if (session_reg == EXPECT_KEY) begin
                hold_key_next = 1'b1;
                session_next  = EXPECT_DATA;
                data_cnt_next = '0;
            end else begin
                hold_key_next = 1'b0;
                if ((DATA_BLOCKS != 0) && (data_cnt_reg == DB_LAST)) begin
                    session_next  = EXPECT_KEY;
                    data_cnt_next = '0;
                end else begin
                    data_cnt_next = data_cnt_reg + DCW'(1);
                end
            end
        end
    end

    assign blk_data    = hold_data_reg;
    assign blk_is_key  = hold_key_reg;
    assign blk_valid   = hold_valid_reg;
    assign err_timeout = err_timeout_reg;
    assign err_overrun = err_overrun_reg;

    block_serializer #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .blk_data  (tx_blk_data),
        .blk_valid (tx_blk_valid),
        .blk_ready (tx_blk_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

endmodule
